// File: rtl/perceptron_commit_pkg.sv
// Shared predictor constants and the table-initialisation FSM state type.
package perceptron_commit_pkg;

    localparam int TABLE_DEPTH = 64;
    localparam int IDX_W       = 6;
    localparam int HIST_W      = 16;
    localparam int WEIGHT_W    = 48;
    localparam int BIAS_W      = 2;
    localparam int STATUS_W    = 2;
    localparam int CNT_W       = 16;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } pc_state_e;

endpackage

// File: rtl/perceptron_commit_ghr_unit.sv
// Global history registers: speculative history advanced by fetch predictions,
// committed history advanced by resolved branches, and misprediction recovery.
module ghr_unit
    import perceptron_commit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              upd_valid,
    input  logic              branch_direction,
    input  logic              mispredict,
    input  logic              pred_valid,
    input  logic              pred_dir,
    output logic [HIST_W-1:0] spec_ghr,
    output logic [HIST_W-1:0] commit_ghr
);

    logic [HIST_W-1:0] commit_next;

    // Committed history with the resolved outcome shifted in (bit 0 is newest).
    always_comb begin
        commit_next = {commit_ghr[HIST_W-2:0], branch_direction};
    end

    // History update: recovery from a mispredict beats a same-cycle prediction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spec_ghr   <= '0;
            commit_ghr <= '0;
        end else if (run) begin
            if (upd_valid) begin
                commit_ghr <= commit_next;
            end
            if (upd_valid && mispredict) begin
                spec_ghr <= commit_next;
            end else if (pred_valid && !mispredict) begin
                spec_ghr <= {spec_ghr[HIST_W-2:0], pred_dir};
            end
        end
    end

endmodule

// File: rtl/perceptron_commit.sv
// Perceptron predictor table with a one-entry write buffer, read bypass,
// power-up clearing sweep, history registers and a misprediction counter.
module perceptron_commit
    import perceptron_commit_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                upd_valid,
    input  logic [IDX_W:1]      upd_index,
    input  logic [WEIGHT_W:1]   upd_weight,
    input  logic [BIAS_W:1]     upd_bias,
    input  logic [STATUS_W:1]   upd_status,
    input  logic                en_2,
    input  logic                en_3,
    input  logic                branch_direction,
    input  logic                mispredict,
    input  logic                pred_valid,
    input  logic                pred_dir,
    input  logic [IDX_W:1]      lookup_index,
    output logic [WEIGHT_W:1]   rd_weight,
    output logic [BIAS_W:1]     rd_bias,
    output logic [STATUS_W:1]   rd_status,
    output logic [HIST_W:1]     spec_GHR,
    output logic [HIST_W:1]     commit_GHR,
    output logic                ready,
    output logic [CNT_W:1]      mispred_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    pc_state_e            state_q, state_d;
    logic [IDX_W-1:0]     init_idx_q, init_idx_d;
    logic                 run;
    logic                 accept;

    logic                 vld_p1;
    logic [IDX_W-1:0]     wb_idx_p1;
    logic [WEIGHT_W-1:0]  wb_weight_p1;
    logic [BIAS_W-1:0]    wb_bias_p1;
    logic [STATUS_W-1:0]  wb_status_p1;
    logic                 wb_en2_p1;
    logic                 wb_en3_p1;

    logic [WEIGHT_W-1:0]  weight_mem [TABLE_DEPTH];
    logic [BIAS_W-1:0]    bias_mem   [TABLE_DEPTH];
    logic [STATUS_W-1:0]  status_mem [TABLE_DEPTH];

    logic [CNT_W-1:0]     cnt_q;
    logic [HIST_W-1:0]    spec_ghr;
    logic [HIST_W-1:0]    commit_ghr;

    assign run         = (state_q == ST_RUN);
    assign ready       = run;
    assign accept      = run && upd_valid && (en_2 || en_3);
    assign mispred_cnt = cnt_q;
    assign spec_GHR    = spec_ghr;
    assign commit_GHR  = commit_ghr;

    // FSM state and clearing-sweep index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
        end
    end

    // Next state: sweep one entry per cycle, enter RUN after the last entry.
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        case (state_q)
            ST_INIT: begin
                init_idx_d = init_idx_q + 1'b1;
                if (init_idx_q == IDX_W'(TABLE_DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // Stage p0 -> p1: write-buffer valid; a new accept replaces a committing entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= accept;
        end
    end

    // Stage p0 -> p1: write-buffer payload, qualified by vld_p1.
    always_ff @(posedge clk) begin
        if (accept) begin
            wb_idx_p1    <= upd_index;
            wb_weight_p1 <= upd_weight;
            wb_bias_p1   <= upd_bias;
            wb_status_p1 <= upd_status;
            wb_en2_p1    <= en_2;
            wb_en3_p1    <= en_3;
        end
    end

    // Stage p1 -> table: clearing sweep in INIT, buffered field writes in RUN.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            weight_mem[init_idx_q] <= '0;
            bias_mem[init_idx_q]   <= '0;
            status_mem[init_idx_q] <= '0;
        end else if (vld_p1) begin
            if (wb_en3_p1) begin
                weight_mem[wb_idx_p1] <= wb_weight_p1;
            end
            if (wb_en2_p1) begin
                bias_mem[wb_idx_p1]   <= wb_bias_p1;
                status_mem[wb_idx_p1] <= wb_status_p1;
            end
        end
    end

    // Fetch read with bypass of enabled fields from a matching buffered update.
    always_comb begin
        rd_weight = weight_mem[lookup_index];
        rd_bias   = bias_mem[lookup_index];
        rd_status = status_mem[lookup_index];
        if (vld_p1 && (wb_idx_p1 == lookup_index)) begin
            if (wb_en3_p1) begin
                rd_weight = wb_weight_p1;
            end
            if (wb_en2_p1) begin
                rd_bias   = wb_bias_p1;
                rd_status = wb_status_p1;
            end
        end
    end

    // Saturating count of resolved mispredictions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (run && upd_valid && mispredict) begin
            cnt_q <= sat_inc(cnt_q);
        end
    end

    ghr_unit u_ghr (
        .clk              (clk),
        .rst              (rst),
        .run              (run),
        .upd_valid        (upd_valid),
        .branch_direction (branch_direction),
        .mispredict       (mispredict),
        .pred_valid       (pred_valid),
        .pred_dir         (pred_dir),
        .spec_ghr         (spec_ghr),
        .commit_ghr       (commit_ghr)
    );

endmodule

// File: doc/perceptron_commit.md
PERCEPTRON_COMMIT -- requirements
Module: perceptron_commit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port upd_valid, input, 1 bit: an update from the EX-stage update logic is present this cycle.
REQ-004 SHALL have port upd_index, input, [6:1]: table entry being updated.
REQ-005 SHALL have ports upd_weight [48:1], upd_bias [2:1] and upd_status [2:1], inputs: new entry contents.
REQ-006 SHALL have ports en_2 and en_3, inputs, 1 bit each: en_2 writes status/bias; en_3 writes weights.
REQ-007 SHALL have ports branch_direction and mispredict, inputs, 1 bit each: resolved outcome of the EX-stage branch.
REQ-008 SHALL have ports pred_valid and pred_dir, inputs, 1 bit each: fetch made a prediction with this direction.
REQ-009 SHALL have port lookup_index, input, [6:1]: fetch read index.
REQ-010 SHALL have ports rd_weight [48:1], rd_bias [2:1] and rd_status [2:1], outputs: combinational read of lookup_index.
REQ-011 SHALL have ports spec_GHR [16:1] and commit_GHR [16:1], outputs: speculative and committed history.
REQ-012 SHALL have port ready, output, 1 bit: table initialised; fetch may use predictions.
REQ-013 SHALL have port mispred_cnt, output, [16:1]: saturating misprediction count.

Function
REQ-014 SHALL hold 64 entries; each entry is weight[48:1], bias[2:1] and status[2:1].
REQ-015 SHALL implement FSM INIT->RUN. INIT clears one entry per cycle, index 0..63, and writes all fields to zero. After index 63 it SHALL enter RUN; INIT lasts exactly 64 cycles.
REQ-016 SHALL drive ready=0 in INIT and ready=1 in RUN. In INIT, upd_valid and pred_valid SHALL be ignored.
REQ-017 SHALL accept an update in RUN when upd_valid=1 and (en_2|en_3)=1. The update is captured into a one-entry write buffer (index, fields, enables) on that edge.
REQ-018 SHALL commit the write buffer to the table on the next edge. Latency from upd_valid to table write is 2 edges.
REQ-019 SHALL write only enabled fields: en_2 writes status and bias; en_3 writes weight. If both are set, all fields are written.
REQ-020 SHALL, on a new accepted update while the buffer is full, commit the old buffer and load the new one on the same edge. No stall and no loss.
REQ-021 SHALL return table data on read, except that enabled fields come from the write buffer when it is valid and its index equals lookup_index (bypass).
REQ-022 SHALL shift commit_GHR as {commit_GHR[15:1], branch_direction} on any RUN cycle with upd_valid=1; GHR[1] is the newest bit.
REQ-023 SHALL shift spec_GHR as {spec_GHR[15:1], pred_dir} when pred_valid=1 and mispredict=0.
REQ-024 SHALL, when upd_valid=1 and mispredict=1, load spec_GHR with {commit_GHR[15:1], branch_direction}, overriding any pred_valid in the same cycle.
REQ-025 SHALL increment mispred_cnt on each upd_valid with mispredict=1, saturating at 16'hFFFF.

Reset
REQ-026 SHALL, while rst=1, asynchronously force: FSM=INIT, init index=0, write buffer invalid, spec_GHR=0, commit_GHR=0, mispred_cnt=0, ready=0.
REQ-027 SHALL, on assertion of rst mid-INIT or mid-RUN, discard any pending write-buffer entry and restart the 64-cycle INIT sweep after rst deasserts.

Structure
REQ-028 SHALL place in the shared predictor package: table depth 64, index width 6, history length 16, weight field width 48, and the FSM state enum.
REQ-029 SHALL isolate history handling in one sub-module, ghr_unit, which holds spec_GHR, commit_GHR and the recovery logic.

Verification
REQ-030 SHALL cover reset release: ready=0 for 64 cycles, ready=1 on cycle 65, and all 64 entries read back as zero.
REQ-031 SHALL cover update then read: upd_index=5, en_3=1, weight=48'h123456789ABC. lookup 5 returns the new weight on the next cycle via bypass and also after the table commit; bias and status are unchanged.
REQ-032 SHALL cover back-to-back updates to indices 3 then 4 on consecutive cycles: both entries hold their new values; no update is lost.
REQ-033 SHALL cover misprediction recovery: commit_GHR=16'h00F0, pred_valid=1, upd_valid=1, mispredict=1, branch_direction=1. spec_GHR becomes 16'h01E1 on the next edge.
REQ-034 SHALL cover counter saturation: preload mispred_cnt=16'hFFFE, then apply 3 mispredicts. mispred_cnt reaches 16'hFFFF and stays there.
REQ-035 SHALL cover reset mid-RUN with the buffer valid: the buffered entry is never written, and INIT restarts from 0.
